// File: rtl/dmem_bus_responder.sv
// Data-memory responder on the CPU load/store bus: lane-steered stores, raw aligned word loads, error replies.
// Latency: pready in cycle 2+WAIT_STATES, counting the setup cycle (request sampled in IDLE) as cycle 1.
// Backpressure: wait states stretch the access phase; psel low in access aborts; next request accepted after pready.
module dmem_bus_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [1:0]  psize,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  // The setup phase is the IDLE cycle in which the request is sampled, so the
  // FSM needs only two states and WAIT_STATES=0 completes every other cycle.
  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  logic        req_write_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [1:0]  req_size_q;

  logic [31:0] prdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             err;
  logic [3:0]       be;
  logic [31:0]      lane_dat;
  logic [31:0]      rd_word;

  // Word offset from the window base; wrap-around below BASE_ADDR lands in the high bits.
  always_comb begin
    word_off = req_addr_q[31:2] - BASE_ADDR[31:2];
    idx      = word_off[IDX_W-1:0];
    rd_word  = mem[idx];
    err      = (|word_off[29:IDX_W])
             || (req_size_q == 2'b11)
             || ((req_size_q == 2'b01) && req_addr_q[0])
             || ((req_size_q == 2'b10) && (req_addr_q[1:0] != 2'b00));
  end

  // Byte-enable and lane replication for the latched store.
  always_comb begin
    be       = 4'b0000;
    lane_dat = req_wdata_q;
    case (req_size_q)
      2'b00: begin
        be       = 4'b0001 << req_addr_q[1:0];
        lane_dat = {4{req_wdata_q[7:0]}};
      end
      2'b01: begin
        be       = req_addr_q[1] ? 4'b1100 : 4'b0011;
        lane_dat = {2{req_wdata_q[15:0]}};
      end
      2'b10: begin
        be       = 4'b1111;
        lane_dat = req_wdata_q;
      end
      default: begin
        be       = 4'b0000;
        lane_dat = req_wdata_q;
      end
    endcase
  end

  // Next-state, wait counter and completion strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    pready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pready  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs: error forces zero data; stores leave the held load data on prdata.
  always_comb begin
    pslverr = pready && err;
    prdata  = prdata_q;
    if (pready) begin
      if (err) begin
        prdata = 32'h0;
      end else if (!req_write_q) begin
        prdata = rd_word;
      end
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured only in the setup cycle; access-phase bus changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_write_q <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_size_q  <= 2'b00;
    end else if (accept) begin
      req_write_q <= pwrite;
      req_addr_q  <= paddr;
      req_wdata_q <= pwdata;
      req_size_q  <= psize;
    end
  end

  // Load data register: updated only by a completed load, held across stores.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prdata_q <= 32'h0;
    end else if (pready && !req_write_q) begin
      prdata_q <= err ? 32'h0 : rd_word;
    end
  end

  // Store commit at the end of the pready cycle; storage is not reset.
  always_ff @(posedge clk) begin
    if (pready && req_write_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= lane_dat[8*b +: 8];
        end
      end
    end
  end

endmodule
